// File: rtl/blank_sched.sv
// blank_sched: line/frame timing controller driving the blank mapper schedule and pixel enable.
// Outputs are registered from the next-cycle position so they line up with the counters.
module blank_sched #(
   parameter int CNT_W  = 16,
   parameter int BS_LEN = 4,
   parameter int BE_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             td_enable,
   input  logic [1:0]       td_lane_count,
   input  logic [CNT_W-1:0] td_h_active,
   input  logic [CNT_W-1:0] td_h_blank,
   input  logic [CNT_W-1:0] td_v_active,
   input  logic [CNT_W-1:0] td_v_blank,
   output logic             sched_blank_en,
   output logic             sched_blank_id,
   output logic [1:0]       sched_blank_state,
   output logic             sched_active_en,
   output logic             sched_sof,
   output logic [CNT_W-1:0] sched_line,
   output logic             sched_cfg_err
);
   localparam int W1 = CNT_W + 1;
   localparam logic [W1-1:0] BS_W = W1'(BS_LEN);
   localparam logic [W1-1:0] BE_W = W1'(BE_LEN);
   localparam logic [W1-1:0] ONE = W1'(1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, nstate;
   logic [W1-1:0] col, l, ha, ht, va, vt, n;
   logic [W1-1:0] ncol, nl, nha, nht, nva, nvt, nn;
   logic [W1-1:0] in_n, in_ht, in_vt, o;
   logic valid, line_end, frame_end, load, nerr;
   logic run, act, bs, start, be;
   always_comb begin
      in_n = td_lane_count == 2'b00 ? W1'(12) : td_lane_count == 2'b01 ? W1'(6) : W1'(3);
      in_ht = {1'b0, td_h_active} + {1'b0, td_h_blank};
      in_vt = {1'b0, td_v_active} + {1'b0, td_v_blank};
      valid = |td_h_active && |td_v_active && |td_v_blank && td_lane_count != 2'b11 &&
              {1'b0, td_h_blank} >= BS_W + BE_W + in_n + ONE;
      line_end = col == ht - ONE;
      frame_end = line_end && l == vt - ONE;
      nstate = state;
      ncol = col;
      nl = l;
      nha = ha;
      nht = ht;
      nva = va;
      nvt = vt;
      nn = n;
      nerr = td_enable && sched_cfg_err;
      load = 1'b0;
      if (!td_enable) begin
         nstate = IDLE;
         ncol = '0;
         nl = '0;
      end else if (state == IDLE) begin
         if (!sched_cfg_err) begin
            load = valid;
            nerr = !valid;
         end
      end else if (frame_end) begin
         // Frame boundary: config is re-latched here or the stream stops.
         load = valid;
         nerr = !valid;
         nstate = IDLE;
         ncol = '0;
         nl = '0;
      end else if (line_end) begin
         ncol = '0;
         nl = l + ONE;
      end else
         ncol = col + ONE;
      if (load) begin
         nstate = RUN;
         ncol = '0;
         nl = '0;
         nha = {1'b0, td_h_active};
         nht = in_ht;
         nva = {1'b0, td_v_active};
         nvt = in_vt;
         nn = in_n;
      end
      run = nstate == RUN;
      o = ncol - nha;
      act = run && ncol < nha && nl < nva;
      bs = ncol >= nha && o < BS_W;
      start = ncol >= nha && !bs && o < BS_W + nn;
      be = ncol >= nha && ncol >= nht - BE_W && (nl + ONE < nva || nl == nvt - ONE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col <= '0;
         l <= '0;
         ha <= '0;
         ht <= '0;
         va <= '0;
         vt <= '0;
         n <= '0;
         sched_blank_en <= 1'b0;
         sched_blank_id <= 1'b0;
         sched_blank_state <= 2'b00;
         sched_active_en <= 1'b0;
         sched_sof <= 1'b0;
         sched_line <= '0;
         sched_cfg_err <= 1'b0;
      end else begin
         state <= nstate;
         col <= ncol;
         l <= nl;
         ha <= nha;
         ht <= nht;
         va <= nva;
         vt <= nvt;
         n <= nn;
         sched_blank_en <= run && !act;
         sched_blank_id <= run && !act && nl + ONE < nva;
         sched_blank_state <= !run || act ? 2'b00 : bs ? 2'b01 : start ? 2'b10 : be ? 2'b11 : 2'b00;
         sched_active_en <= act;
         sched_sof <= run && nl == '0 && ncol == '0;
         sched_line <= run ? nl[CNT_W-1:0] : '0;
         sched_cfg_err <= nerr;
      end
   end
endmodule

// File: tb/tb_blank_sched.sv
// tb_blank_sched: vector table, corner sequences and a frame-expanding reference model.
module tb_blank_sched;
   logic clk = 0, rst = 1, en = 0;
   logic [1:0] lanes = 2'b10;
   logic [15:0] h_active = 8, h_blank = 24, v_active = 2, v_blank = 2;
   logic blank_en, blank_id, active_en, sof, cfg_err;
   logic [1:0] blank_state;
   logic [15:0] line;
   logic [22:0] outv, e;
   int checks = 0, errors = 0;
   logic [22:0] q[$];
   bit m_run = 0, m_err = 0;

   blank_sched dut (
      .clk(clk), .rst(rst), .td_enable(en), .td_lane_count(lanes),
      .td_h_active(h_active), .td_h_blank(h_blank), .td_v_active(v_active), .td_v_blank(v_blank),
      .sched_blank_en(blank_en), .sched_blank_id(blank_id), .sched_blank_state(blank_state),
      .sched_active_en(active_en), .sched_sof(sof), .sched_line(line), .sched_cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   assign outv = {blank_en, blank_id, blank_state, active_en, sof, cfg_err, line};

   function automatic logic [22:0] mk(bit b, bit id, logic [1:0] st, bit a, bit s, bit er, logic [15:0] ln);
      return {b, id, st, a, s, er, ln};
   endfunction

   task automatic chk(string nm, logic [22:0] got, logic [22:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got en/id/st/act/sof/err/line=%h required %h", nm, got, exp);
      end
   endtask

   function automatic int nlen(logic [1:0] ln);
      return ln == 2'b00 ? 12 : ln == 2'b01 ? 6 : 3;
   endfunction

   function automatic bit ok(logic [1:0] ln, int ha, int hb, int va, int vb);
      return ha >= 1 && va >= 1 && vb >= 1 && ln != 2'b11 && hb >= 9 + nlen(ln);
   endfunction

   // Expands one whole frame into per-cycle expected outputs.
   task automatic build(logic [1:0] ln, int ha, int hb, int va, int vb);
      int ht = ha + hb, vt = va + vb, nn = nlen(ln);
      for (int li = 0; li < vt; li++)
         for (int c = 0; c < ht; c++) begin
            bit a = li < va && c < ha;
            logic [1:0] st = 2'b00;
            if (c >= ha) begin
               if (c - ha < 4) st = 2'b01;
               else if (c - ha < 4 + nn) st = 2'b10;
               else if (c >= ht - 4 && ((li + 1) % vt) < va) st = 2'b11;
            end
            q.push_back(mk(!a, !a && li < va - 1, st, a, li == 0 && c == 0, 0, 16'(li)));
         end
   endtask

   task automatic step(output logic [22:0] ex);
      if (!en) begin
         m_run = 0;
         m_err = 0;
         q.delete();
         ex = '0;
      end else if (m_run && q.size() > 0)
         ex = q.pop_front();
      else if (!m_err && ok(lanes, int'(h_active), int'(h_blank), int'(v_active), int'(v_blank))) begin
         build(lanes, int'(h_active), int'(h_blank), int'(v_active), int'(v_blank));
         m_run = 1;
         ex = q.pop_front();
      end else begin
         m_run = 0;
         m_err = 1;
         ex = mk(0, 0, 0, 0, 0, 1, 0);
      end
   endtask

   task automatic do_reset();
      en = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic cfg(logic [1:0] ln, int ha, int hb, int va, int vb);
      lanes = ln;
      h_active = 16'(ha);
      h_blank = 16'(hb);
      v_active = 16'(va);
      v_blank = 16'(vb);
   endtask

   typedef struct {
      string nm;
      logic [1:0] ln;
      int ha, hb, va, vb, cyc;
      logic [22:0] exp;
   } vec_t;
   vec_t vt[$];

   initial begin
      vt.push_back('{"base_l0c0", 2'b10, 8, 24, 2, 2, 0, mk(0, 0, 0, 1, 1, 0, 0)});
      vt.push_back('{"base_l0c7", 2'b10, 8, 24, 2, 2, 7, mk(0, 0, 0, 1, 0, 0, 0)});
      vt.push_back('{"base_l0_bs", 2'b10, 8, 24, 2, 2, 8, mk(1, 1, 1, 0, 0, 0, 0)});
      vt.push_back('{"base_l0_start", 2'b10, 8, 24, 2, 2, 12, mk(1, 1, 2, 0, 0, 0, 0)});
      vt.push_back('{"base_l0_start_end", 2'b10, 8, 24, 2, 2, 14, mk(1, 1, 2, 0, 0, 0, 0)});
      vt.push_back('{"base_l0_blank", 2'b10, 8, 24, 2, 2, 15, mk(1, 1, 0, 0, 0, 0, 0)});
      vt.push_back('{"base_l0_be", 2'b10, 8, 24, 2, 2, 28, mk(1, 1, 3, 0, 0, 0, 0)});
      vt.push_back('{"base_l0_be_end", 2'b10, 8, 24, 2, 2, 31, mk(1, 1, 3, 0, 0, 0, 0)});
      vt.push_back('{"base_l1_bs", 2'b10, 8, 24, 2, 2, 40, mk(1, 0, 1, 0, 0, 0, 1)});
      vt.push_back('{"base_l1_no_be", 2'b10, 8, 24, 2, 2, 63, mk(1, 0, 0, 0, 0, 0, 1)});
      vt.push_back('{"base_l2_vblank", 2'b10, 8, 24, 2, 2, 64, mk(1, 0, 0, 0, 0, 0, 2)});
      vt.push_back('{"base_l2_bs", 2'b10, 8, 24, 2, 2, 72, mk(1, 0, 1, 0, 0, 0, 2)});
      vt.push_back('{"base_l3_be", 2'b10, 8, 24, 2, 2, 124, mk(1, 0, 3, 0, 0, 0, 3)});
      vt.push_back('{"base_sof_wrap", 2'b10, 8, 24, 2, 2, 128, mk(0, 0, 0, 1, 1, 0, 0)});
      vt.push_back('{"lane1_start0", 2'b00, 8, 21, 2, 2, 12, mk(1, 1, 2, 0, 0, 0, 0)});
      vt.push_back('{"lane1_start_end", 2'b00, 8, 21, 2, 2, 23, mk(1, 1, 2, 0, 0, 0, 0)});
      vt.push_back('{"lane1_one_blank", 2'b00, 8, 21, 2, 2, 24, mk(1, 1, 0, 0, 0, 0, 0)});
      vt.push_back('{"lane1_be0", 2'b00, 8, 21, 2, 2, 25, mk(1, 1, 3, 0, 0, 0, 0)});
      vt.push_back('{"lane1_be_end", 2'b00, 8, 21, 2, 2, 28, mk(1, 1, 3, 0, 0, 0, 0)});
      vt.push_back('{"lane1_l1", 2'b00, 8, 21, 2, 2, 29, mk(0, 0, 0, 1, 0, 0, 1)});
      vt.push_back('{"lane1_hb20_err", 2'b00, 8, 20, 2, 2, 0, mk(0, 0, 0, 0, 0, 1, 0)});
      vt.push_back('{"lane1_hb20_err_hold", 2'b00, 8, 20, 2, 2, 5, mk(0, 0, 0, 0, 0, 1, 0)});
      vt.push_back('{"lane11_err", 2'b11, 8, 24, 2, 2, 0, mk(0, 0, 0, 0, 0, 1, 0)});

      @(negedge clk);
      chk("reset_state", outv, '0);
      rst = 0;
      foreach (vt[i]) begin
         do_reset();
         cfg(vt[i].ln, vt[i].ha, vt[i].hb, vt[i].va, vt[i].vb);
         en = 1;
         repeat (vt[i].cyc + 1) @(negedge clk);
         chk(vt[i].nm, outv, vt[i].exp);
      end

      do_reset();
      cfg(2'b10, 8, 24, 2, 2);
      en = 1;
      repeat (41) @(negedge clk);
      h_active = 16;
      repeat (64) @(negedge clk);
      chk("midwrite_old_l3_bs", outv, mk(1, 0, 1, 0, 0, 0, 3));
      repeat (24) @(negedge clk);
      chk("midwrite_new_sof", outv, mk(0, 0, 0, 1, 1, 0, 0));
      repeat (8) @(negedge clk);
      chk("midwrite_new_active_c8", outv, mk(0, 0, 0, 1, 0, 0, 0));
      repeat (8) @(negedge clk);
      chk("midwrite_new_bs_c16", outv, mk(1, 1, 1, 0, 0, 0, 0));
      repeat (24) @(negedge clk);
      chk("midwrite_new_l1", outv, mk(0, 0, 0, 1, 0, 0, 1));

      do_reset();
      cfg(2'b10, 8, 24, 2, 2);
      en = 1;
      repeat (41) @(negedge clk);
      lanes = 2'b11;
      repeat (87) @(negedge clk);
      chk("wrap_err_last_cycle", outv, mk(1, 0, 3, 0, 0, 0, 3));
      @(negedge clk);
      chk("wrap_err_idle", outv, mk(0, 0, 0, 0, 0, 1, 0));
      en = 0;
      @(negedge clk);
      chk("wrap_err_clear", outv, '0);

      do_reset();
      cfg(2'b10, 8, 24, 2, 2);
      en = 1;
      repeat (14) @(negedge clk);
      chk("dis_mid_start", outv, mk(1, 1, 2, 0, 0, 0, 0));
      en = 0;
      @(negedge clk);
      chk("dis_zero", outv, '0);
      en = 1;
      @(negedge clk);
      chk("dis_restart", outv, mk(0, 0, 0, 1, 1, 0, 0));

      do_reset();
      en = 1;
      repeat (10) @(negedge clk);
      chk("rst_pre_bs", outv, mk(1, 1, 1, 0, 0, 0, 0));
      #2 rst = 1;
      #1 chk("rst_async_zero", outv, '0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_restart", outv, mk(0, 0, 0, 1, 1, 0, 0));

      do_reset();
      m_run = 0;
      m_err = 0;
      q.delete();
      en = 1;
      for (int k = 0; k < 4000; k++) begin
         if (!en ? $urandom_range(0, 3) == 0 : $urandom_range(0, 79) == 0) en = !en;
         if ($urandom_range(0, 29) == 0)
            cfg(2'($urandom_range(0, 3)), $urandom_range(0, 10), $urandom_range(12, 30),
                $urandom_range(0, 3), $urandom_range(0, 3));
         step(e);
         @(negedge clk);
         chk("random", outv, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
